// File: rtl/sm_event_mon_pkg.sv
// Shared definitions for the sm_event_monitor slice: supervisor state encodings
// and the saturating-increment helper used by the event counters.
package sm_event_mon_pkg;

    localparam logic [1:0] ST_IDLE   = 2'b00;
    localparam logic [1:0] ST_ACTIVE = 2'b01;
    localparam logic [1:0] ST_FAULT  = 2'b10;

    // Saturating increment on a 32-bit carrier; callers narrow the result.
    function automatic logic [31:0] sat_inc(input logic [31:0] value,
                                            input logic [31:0] max_value,
                                            input logic        inc);
        logic [31:0] result;
        result = value;
        if (inc && (value < max_value)) begin
            result = value + 32'd1;
        end
        return result;
    endfunction

endpackage

// File: rtl/sm_sat_counter.sv
// Saturating up-counter with synchronous reset and synchronous clear.
module sm_sat_counter
    import sm_event_mon_pkg::*;
#(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clr,
    input  logic             i_inc,
    output logic [CNT_W-1:0] o_cnt
);

    localparam logic [CNT_W-1:0] MAX_V = '1;

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_next;

    always_comb begin
        w_next = CNT_W'(sat_inc(32'(r_cnt), 32'(MAX_V), i_inc));
    end

    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= w_next;
        end
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/sm_event_monitor.sv
// Edge-detecting event monitor with saturating counters and an IDLE/ACTIVE/FAULT
// supervisor. Optional irq output when SM_EVENT_MON_IRQ_EN is defined.
module sm_event_monitor
    import sm_event_mon_pkg::*;
#(
    parameter int unsigned CNT_W     = 8,
    parameter int unsigned ERR_LIMIT = 3,
    parameter int unsigned TIMEOUT   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             o1,
    input  logic             o2,
    input  logic             err,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt_o1,
    output logic [CNT_W-1:0] cnt_o2,
    output logic [CNT_W-1:0] cnt_err,
    output logic [1:0]       state,
    output logic             fault
`ifdef SM_EVENT_MON_IRQ_EN
    ,
    output logic             irq
`endif
);

    localparam int unsigned      TMO_W    = $clog2(TIMEOUT);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

    logic             r_prev_o1;
    logic             r_prev_o2;
    logic             r_prev_err;
    logic [1:0]       r_state;
    logic             r_fault;
    logic [TMO_W-1:0] r_tmo;

    logic             w_rise_o1;
    logic             w_rise_o2;
    logic             w_rise_err;
    logic             w_activity;
    logic [31:0]      w_err_sum;
    logic             w_err_hit;
    logic [1:0]       w_state_next;
    logic [TMO_W-1:0] w_tmo_next;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_prev_o1  <= 1'b0;
            r_prev_o2  <= 1'b0;
            r_prev_err <= 1'b0;
        end else begin
            r_prev_o1  <= o1;
            r_prev_o2  <= o2;
            r_prev_err <= err;
        end
    end

    assign w_rise_o1  = o1  & ~r_prev_o1;
    assign w_rise_o2  = o2  & ~r_prev_o2;
    assign w_rise_err = err & ~r_prev_err;
    assign w_activity = w_rise_o1 | w_rise_o2;

    sm_sat_counter #(.CNT_W(CNT_W)) u_cnt_o1 (
        .clk   (clk),
        .rst   (rst),
        .i_clr (clr),
        .i_inc (w_rise_o1),
        .o_cnt (cnt_o1)
    );

    sm_sat_counter #(.CNT_W(CNT_W)) u_cnt_o2 (
        .clk   (clk),
        .rst   (rst),
        .i_clr (clr),
        .i_inc (w_rise_o2),
        .o_cnt (cnt_o2)
    );

    sm_sat_counter #(.CNT_W(CNT_W)) u_cnt_err (
        .clk   (clk),
        .rst   (rst),
        .i_clr (clr),
        .i_inc (w_rise_err),
        .o_cnt (cnt_err)
    );

    // Fault trips on the cycle the ERR_LIMIT-th edge is sampled, not a cycle later.
    assign w_err_sum = 32'(cnt_err) + 32'(w_rise_err);
    assign w_err_hit = (w_err_sum >= 32'(ERR_LIMIT));

    always_comb begin
        w_state_next = r_state;
        w_tmo_next   = r_tmo;
        if (clr) begin
            w_state_next = ST_IDLE;
            w_tmo_next   = '0;
        end else if ((r_state != ST_FAULT) && w_err_hit) begin
            w_state_next = ST_FAULT;
            w_tmo_next   = '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_activity) begin
                        w_state_next = ST_ACTIVE;
                        w_tmo_next   = '0;
                    end
                end
                ST_ACTIVE: begin
                    if (w_activity) begin
                        w_tmo_next = '0;
                    end else if (r_tmo == TMO_LAST) begin
                        w_state_next = ST_IDLE;
                        w_tmo_next   = '0;
                    end else begin
                        w_tmo_next = r_tmo + TMO_W'(1);
                    end
                end
                default: begin
                    w_state_next = r_state;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_fault <= 1'b0;
            r_tmo   <= '0;
        end else begin
            r_state <= w_state_next;
            r_fault <= (w_state_next == ST_FAULT);
            r_tmo   <= w_tmo_next;
        end
    end

    assign state = r_state;
    assign fault = r_fault;

`ifdef SM_EVENT_MON_IRQ_EN
    logic r_irq;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_irq <= 1'b0;
        end else begin
            r_irq <= (w_state_next == ST_FAULT) && (r_state != ST_FAULT);
        end
    end

    assign irq = r_irq;
`endif

endmodule

// File: tb/tb_sm_event_monitor.sv
// Self-checking bench for sm_event_monitor: directed steps followed by random
// traffic, all compared against a cycle-count based reference model.
module tb_sm_event_monitor;

    localparam int unsigned CNT_W     = 4;
    localparam int unsigned ERR_LIMIT = 3;
    localparam int unsigned TIMEOUT   = 16;
    localparam int          MAXC      = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             o1  = 1'b0;
    logic             o2  = 1'b0;
    logic             err = 1'b0;
    logic             clr = 1'b0;
    logic [CNT_W-1:0] cnt_o1;
    logic [CNT_W-1:0] cnt_o2;
    logic [CNT_W-1:0] cnt_err;
    logic [1:0]       state;
    logic             fault;
`ifdef SM_EVENT_MON_IRQ_EN
    logic             irq;
`endif

    int n_vec  = 0;
    int n_fail = 0;

    // Reference model: counts, supervisor state, and cycle of last o1/o2 edge.
    int m_c1, m_c2, m_ce, m_state, m_fault, m_irq;
    bit m_p1, m_p2, m_pe;
    int m_cyc, m_last_act;

    sm_event_monitor #(
        .CNT_W     (CNT_W),
        .ERR_LIMIT (ERR_LIMIT),
        .TIMEOUT   (TIMEOUT)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .o1      (o1),
        .o2      (o2),
        .err     (err),
        .clr     (clr),
        .cnt_o1  (cnt_o1),
        .cnt_o2  (cnt_o2),
        .cnt_err (cnt_err),
        .state   (state),
        .fault   (fault)
`ifdef SM_EVENT_MON_IRQ_EN
        ,
        .irq     (irq)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int min_i(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    task automatic model_update(input bit r, input bit c, input bit a, input bit b, input bit e);
        bit r1, r2, re;
        int old_ce;
        m_cyc++;
        m_irq = 0;
        if (r || c) begin
            m_c1 = 0; m_c2 = 0; m_ce = 0;
            m_p1 = 0; m_p2 = 0; m_pe = 0;
            m_state = 0; m_fault = 0;
            return;
        end
        r1 = a && !m_p1;
        r2 = b && !m_p2;
        re = e && !m_pe;
        m_p1 = a; m_p2 = b; m_pe = e;
        old_ce = m_ce;
        m_c1 = min_i(m_c1 + int'(r1), MAXC);
        m_c2 = min_i(m_c2 + int'(r2), MAXC);
        m_ce = min_i(m_ce + int'(re), MAXC);
        if (m_state != 2 && old_ce + int'(re) >= int'(ERR_LIMIT)) begin
            m_state = 2;
            m_irq   = 1;
        end else if (r1 || r2) begin
            if (m_state != 2) m_state = 1;
            m_last_act = m_cyc;
        end else if (m_state == 1 && (m_cyc - m_last_act) >= int'(TIMEOUT)) begin
            m_state = 0;
        end
        m_fault = (m_state == 2) ? 1 : 0;
    endtask

    // One clock: drive inputs, let the edge happen, then compare on the falling edge.
    task automatic step(input bit r, input bit c, input bit a, input bit b, input bit e);
        rst = r; clr = c; o1 = a; o2 = b; err = e;
        @(posedge clk);
        model_update(r, c, a, b, e);
        @(negedge clk);
        chk("cnt_o1",  32'(cnt_o1),  32'(m_c1));
        chk("cnt_o2",  32'(cnt_o2),  32'(m_c2));
        chk("cnt_err", 32'(cnt_err), 32'(m_ce));
        chk("state",   32'(state),   32'(m_state));
        chk("fault",   32'(fault),   32'(m_fault));
`ifdef SM_EVENT_MON_IRQ_EN
        chk("irq",     32'(irq),     32'(m_irq));
`endif
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0);
    endtask

    initial begin
        m_c1 = 0; m_c2 = 0; m_ce = 0; m_state = 0; m_fault = 0; m_irq = 0;
        m_p1 = 0; m_p2 = 0; m_pe = 0; m_cyc = 0; m_last_act = 0;
        @(negedge clk);

        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        idle(3);
        chk("rst_cnt_o1", 32'(cnt_o1), 32'd0);
        chk("rst_state",  32'(state),  32'd0);
        chk("rst_fault",  32'(fault),  32'd0);

        step(0, 0, 1, 0, 0);
        chk("first_edge_active", 32'(state), 32'd1);
        idle(2);
        for (int p = 0; p < 2; p++) begin
            step(0, 0, 1, 0, 0);
            idle(2);
        end
        chk("o1_three_pulses", 32'(cnt_o1), 32'd3);
        for (int i = 0; i < 5; i++) step(0, 0, 1, 0, 0);
        chk("o1_held_once", 32'(cnt_o1), 32'd4);
        idle(20);
        chk("idle_after_quiet", 32'(state), 32'd0);

        step(0, 0, 0, 1, 0);
        idle(15);
        chk("tmo_still_active", 32'(state), 32'd1);
        idle(1);
        chk("tmo_exact_idle", 32'(state), 32'd0);

        step(0, 0, 0, 1, 0);
        idle(14);
        step(0, 0, 0, 1, 0);
        idle(15);
        chk("tmo_restart_active", 32'(state), 32'd1);
        idle(1);
        chk("tmo_restart_idle", 32'(state), 32'd0);

        step(0, 0, 0, 0, 1);
        idle(1);
        step(0, 0, 0, 0, 1);
        idle(1);
        step(0, 0, 0, 0, 1);
        chk("err_count", 32'(cnt_err), 32'd3);
        chk("err_fault_state", 32'(state), 32'd2);
        chk("err_fault_flag", 32'(fault), 32'd1);
        idle(1);
        step(0, 0, 1, 0, 0);
        idle(1);
        step(0, 0, 1, 0, 0);
        idle(1);
        chk("count_in_fault", 32'(cnt_o1), 32'd6);
        chk("fault_sticky", 32'(state), 32'd2);

        step(0, 1, 1, 0, 0);
        chk("clr_cnt_o1", 32'(cnt_o1), 32'd0);
        chk("clr_state", 32'(state), 32'd0);
        chk("clr_fault", 32'(fault), 32'd0);
        step(0, 0, 1, 0, 0);
        chk("post_clr_edge", 32'(cnt_o1), 32'd1);
        chk("post_clr_active", 32'(state), 32'd1);

        for (int i = 0; i < 20; i++) begin
            step(0, 0, 0, 1, 0);
            step(0, 0, 0, 0, 0);
        end
        chk("o2_saturate", 32'(cnt_o2), 32'd15);
        step(1, 0, 0, 1, 1);
        chk("mid_rst_cnt_o2", 32'(cnt_o2), 32'd0);
        chk("mid_rst_state", 32'(state), 32'd0);

        for (int i = 0; i < 600; i++) begin
            bit r, c, a, b, e, quiet;
            quiet = ((i / 50) % 2) == 1;
            r = ($urandom_range(0, 79) == 0);
            c = ($urandom_range(0, 39) == 0);
            a = quiet ? ($urandom_range(0, 24) == 0) : ($urandom_range(0, 2) == 0);
            b = quiet ? ($urandom_range(0, 24) == 0) : ($urandom_range(0, 2) == 0);
            e = ($urandom_range(0, 11) == 0);
            step(r, c, a, b, e);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
